mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 125 ++++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single fixed-latency memory.
// One transaction in flight at a time: IDLE -> ACCESS (MEM_LAT cycles) -> RESP -> IDLE.
module mem_arbiter #(
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned AW      = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  // fetch port
  input  logic          if_req_valid,
  output logic          if_req_ready,
  input  logic [AW-1:0] if_addr,
  output logic          if_rsp_valid,
  output logic [31:0]   if_rsp_data,
  // data port
  input  logic          d_req_valid,
  output logic          d_req_ready,
  input  logic [AW-1:0] d_addr,
  input  logic          d_we,
  input  logic [31:0]   d_wdata,
  output logic          d_rsp_valid,
  output logic [31:0]   d_rsp_data,
  // shared memory
  output logic [AW-1:0] mem_address,
  output logic [31:0]   mem_write_data,
  output logic          mem_write_enable,
  input  logic [31:0]   mem_read_data,
  output logic          busy
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] RESP   = 2'd2;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_D  = 1'b1;

  localparam logic [1:0] LAST_CNT = 2'(MEM_LAT - 1);

  logic [1:0]    state_q, state_d;
  logic          port_q;
  logic          we_q;
  logic          last_grant_q;
  logic [1:0]    cnt_q;
  logic [AW-1:0] mem_address_q;
  logic [31:0]   mem_write_data_q;
  logic [31:0]   if_rsp_data_q;
  logic [31:0]   d_rsp_data_q;

  logic grant_if, grant_d, grant, last_access;

  // On a tie the port that did not win last time is served.
  always_comb begin
    grant_if = 1'b0;
    grant_d  = 1'b0;
    if (state_q == IDLE) begin
      if (if_req_valid && (!d_req_valid || last_grant_q == PORT_D)) begin
        grant_if = 1'b1;
      end else if (d_req_valid) begin
        grant_d = 1'b1;
      end
    end
  end

  assign grant       = grant_if | grant_d;
  assign last_access = (state_q == ACCESS) && (cnt_q == LAST_CNT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant) state_d = ACCESS;
      ACCESS:  if (last_access) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      port_q           <= PORT_IF;
      we_q             <= 1'b0;
      last_grant_q     <= PORT_D;
      cnt_q            <= 2'd0;
      mem_address_q    <= '0;
      mem_write_data_q <= 32'd0;
      if_rsp_data_q    <= 32'd0;
      d_rsp_data_q     <= 32'd0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        port_q        <= grant_d;
        last_grant_q  <= grant_d;
        we_q          <= grant_d & d_we;
        mem_address_q <= grant_d ? d_addr : if_addr;
        cnt_q         <= 2'd0;
        // Fetches leave the write-data bus at its previous value.
        if (grant_d) begin
          mem_write_data_q <= d_wdata;
        end
      end else if ((state_q == ACCESS) && !last_access) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (last_access) begin
        if (port_q == PORT_D) begin
          d_rsp_data_q <= we_q ? 32'd0 : mem_read_data;
        end else begin
          if_rsp_data_q <= mem_read_data;
        end
      end
    end
  end

  assign if_req_ready     = grant_if;
  assign d_req_ready      = grant_d;
  assign mem_address      = mem_address_q;
  assign mem_write_data   = mem_write_data_q;
  assign mem_write_enable = (state_q == ACCESS) && (cnt_q == 2'd0) && we_q;
  assign if_rsp_valid     = (state_q == RESP) && (port_q == PORT_IF);
  assign d_rsp_valid      = (state_q == RESP) && (port_q == PORT_D);
  assign if_rsp_data      = if_rsp_data_q;
  assign d_rsp_data       = d_rsp_data_q;
  assign busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios, then random traffic on MEM_LAT=1 and MEM_LAT=3
// instances checked against a transaction-level reference model.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [1:0]       ifv, ifr, ifrv, dv, dr, dwe, drv, mwe, busy;
  logic [1:0][31:0] ifa, ifrd, da, dwd, drd, ma, mwd, mrd;
  logic [31:0]      mem    [2][256];
  logic [31:0]      shadow [2][256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter #(
      .MEM_LAT((g == 0) ? 1 : 3),
      .AW(32)
    ) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .if_req_valid(ifv[g]),
      .if_req_ready(ifr[g]),
      .if_addr(ifa[g]),
      .if_rsp_valid(ifrv[g]),
      .if_rsp_data(ifrd[g]),
      .d_req_valid(dv[g]),
      .d_req_ready(dr[g]),
      .d_addr(da[g]),
      .d_we(dwe[g]),
      .d_wdata(dwd[g]),
      .d_rsp_valid(drv[g]),
      .d_rsp_data(drd[g]),
      .mem_address(ma[g]),
      .mem_write_data(mwd[g]),
      .mem_write_enable(mwe[g]),
      .mem_read_data(mrd[g]),
      .busy(busy[g])
    );
    assign mrd[g] = mem[g][ma[g][7:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic idle_inputs();
    ifv = '0; dv = '0; dwe = '0;
    ifa = '0; da = '0; dwd = '0;
  endtask

  task automatic chk_reset(input int g);
    chk("rst_if_ready", ifr[g], 0);
    chk("rst_d_ready", dr[g], 0);
    chk("rst_if_rsp_valid", ifrv[g], 0);
    chk("rst_d_rsp_valid", drv[g], 0);
    chk("rst_mwe", mwe[g], 0);
    chk("rst_busy", busy[g], 0);
    chk("rst_mem_address", ma[g], 0);
    chk("rst_mem_wdata", mwd[g], 0);
    chk("rst_if_rsp_data", ifrd[g], 0);
    chk("rst_d_rsp_data", drd[g], 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference model state, one slot per instance.
  int          lat[2] = '{1, 3};
  int          free_at[2], gc[2], rspc[2];
  logic        lastg[2], pv[2], pport[2], pwe[2], hs_if[2], hs_d[2];
  logic [31:0] paddr[2], pwd[2], prd[2], exp_ma[2], exp_ifd[2], exp_dd[2];

  initial begin
    logic [31:0] exp_data;
    logic        idle, eig, edg, acc;

    idle_inputs();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 256; i++) mem[g][i] = $urandom;
    end
    #12;
    chk_reset(0);
    chk_reset(1);

    // Fetch granted in the first cycle after reset release, MEM_LAT=1
    mem[0][8'h10] = 32'h00500093;
    @(negedge clk);
    ifv[0] = 1'b1; ifa[0] = 32'h10; rst_n = 1'b1;
    #1;
    chk("fetch_ready_T", ifr[0], 1);
    chk("fetch_busy_T", busy[0], 0);
    @(negedge clk); ifv[0] = 1'b0; #1;
    chk("fetch_addr_T1", ma[0], 32'h10);
    chk("fetch_mwe_T1", mwe[0], 0);
    chk("fetch_rsp_T1", ifrv[0], 0);
    chk("fetch_busy_T1", busy[0], 1);
    @(negedge clk); #1;
    chk("fetch_rsp_T2", ifrv[0], 1);
    chk("fetch_data_T2", ifrd[0], 32'h00500093);
    chk("fetch_drsp_T2", drv[0], 0);
    @(negedge clk); #1;
    chk("fetch_busy_T3", busy[0], 0);
    chk("fetch_rsp_T3", ifrv[0], 0);
    chk("fetch_data_hold", ifrd[0], 32'h00500093);

    // Store
    @(negedge clk);
    dv[0] = 1'b1; dwe[0] = 1'b1; da[0] = 32'h4; dwd[0] = 32'hDEADBEEF;
    #1;
    chk("store_ready_T", dr[0], 1);
    chk("store_mwe_T", mwe[0], 0);
    @(negedge clk); dv[0] = 1'b0; #1;
    chk("store_mwe_T1", mwe[0], 1);
    chk("store_addr_T1", ma[0], 32'h4);
    chk("store_wdata_T1", mwd[0], 32'hDEADBEEF);
    chk("store_rsp_T1", drv[0], 0);
    @(negedge clk); #1;
    chk("store_mwe_T2", mwe[0], 0);
    chk("store_rsp_T2", drv[0], 1);
    chk("store_data_T2", drd[0], 0);
    @(negedge clk); #1;
    chk("store_mwe_T3", mwe[0], 0);
    chk("store_addr_hold", ma[0], 32'h4);
    chk("store_wdata_hold", mwd[0], 32'hDEADBEEF);

    // Both ports valid continuously after reset: fetch, data, fetch, data every 3 cycles
    @(negedge clk);
    rst_n = 1'b0; idle_inputs(); #1; rst_n = 1'b1;
    ifv[0] = 1'b1; ifa[0] = 32'h20; dv[0] = 1'b1; da[0] = 32'h24;
    #1;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(negedge clk); #1;
      end
      chk("alt_if_ready", ifr[0], (c % 3 == 0) && ((c / 3) % 2 == 0));
      chk("alt_d_ready", dr[0], (c % 3 == 0) && ((c / 3) % 2 == 1));
    end
    @(negedge clk); idle_inputs();

    // Reset during the store's ACCESS cycle
    @(negedge clk);
    dv[0] = 1'b1; dwe[0] = 1'b1; da[0] = 32'h30; dwd[0] = $urandom;
    #1;
    chk("abort_store_ready", dr[0], 1);
    @(negedge clk);
    dv[0] = 1'b0; dwe[0] = 1'b0; ifv[0] = 1'b1; ifa[0] = 32'h34;
    #1;
    chk("abort_mwe_before", mwe[0], 1);
    chk("abort_if_ignored", ifr[0], 0);
    #1; rst_n = 1'b0; #1;
    chk("abort_mwe_now", mwe[0], 0);
    chk("abort_busy", busy[0], 0);
    chk("abort_drsp", drv[0], 0);
    chk("abort_addr", ma[0], 0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("abort_fetch_ready", ifr[0], 1);
    chk("abort_drsp_r0", drv[0], 0);
    @(negedge clk); ifv[0] = 1'b0; #1;
    chk("abort_drsp_r1", drv[0], 0);
    chk("abort_fetch_addr", ma[0], 32'h34);
    @(negedge clk); #1;
    chk("abort_fetch_rsp", ifrv[0], 1);
    chk("abort_drsp_r2", drv[0], 0);

    // Load on the MEM_LAT=3 instance
    @(negedge clk);
    dv[1] = 1'b1; da[1] = 32'h8; dwe[1] = 1'b0;
    exp_data = mem[1][8];
    #1;
    chk("lat3_ready", dr[1], 1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk); dv[1] = 1'b0; #1;
      chk("lat3_addr_held", ma[1], 32'h8);
      chk("lat3_no_rsp", drv[1], 0);
      chk("lat3_busy", busy[1], 1);
      chk("lat3_mwe", mwe[1], 0);
    end
    @(negedge clk); #1;
    chk("lat3_rsp", drv[1], 1);
    chk("lat3_data", drd[1], exp_data);
    @(negedge clk); #1;
    chk("lat3_rsp_end", drv[1], 0);
    chk("lat3_idle", busy[1], 0);

    // Random traffic on both instances against the transaction model
    @(negedge clk);
    rst_n = 1'b0; idle_inputs();
    for (int g = 0; g < 2; g++) begin
      for (int i = 0; i < 256; i++) shadow[g][i] = mem[g][i];
      free_at[g] = 0; lastg[g] = 1'b1; pv[g] = 1'b0;
      hs_if[g] = 1'b0; hs_d[g] = 1'b0;
      gc[g] = 0; rspc[g] = 0; pport[g] = 1'b0; pwe[g] = 1'b0;
      paddr[g] = '0; pwd[g] = '0; prd[g] = '0;
      exp_ma[g] = '0; exp_ifd[g] = '0; exp_dd[g] = '0;
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      if (c == 0) rst_n = 1'b1;
      for (int g = 0; g < 2; g++) begin
        if (hs_if[g] || !ifv[g]) begin
          ifv[g] = ($urandom_range(2, 0) != 0);
          ifa[g] = $urandom_range(15, 0);
        end
        if (hs_d[g] || !dv[g]) begin
          dv[g]  = ($urandom_range(2, 0) != 0);
          da[g]  = $urandom_range(15, 0);
          dwe[g] = $urandom_range(1, 0);
          dwd[g] = $urandom;
        end
      end
      #1;
      for (int g = 0; g < 2; g++) begin
        idle = (c >= free_at[g]);
        eig  = idle && ifv[g] && (!dv[g] || lastg[g]);
        edg  = idle && dv[g] && !eig;
        acc  = pv[g] && (c > gc[g]) && (c <= gc[g] + lat[g]);
        chk("rnd_if_ready", ifr[g], eig);
        chk("rnd_d_ready", dr[g], edg);
        chk("rnd_busy", busy[g], !idle);
        chk("rnd_mem_address", ma[g], exp_ma[g]);
        chk("rnd_mwe", mwe[g], acc && pwe[g] && (c == gc[g] + 1));
        if (acc && pwe[g]) chk("rnd_mem_wdata", mwd[g], pwd[g]);
        if (pv[g] && c == rspc[g]) begin
          if (pport[g]) exp_dd[g] = prd[g];
          else exp_ifd[g] = prd[g];
        end
        chk("rnd_if_rsp_valid", ifrv[g], pv[g] && (c == rspc[g]) && !pport[g]);
        chk("rnd_d_rsp_valid", drv[g], pv[g] && (c == rspc[g]) && pport[g]);
        chk("rnd_if_rsp_data", ifrd[g], exp_ifd[g]);
        chk("rnd_d_rsp_data", drd[g], exp_dd[g]);
        hs_if[g] = ifr[g] & ifv[g];
        hs_d[g]  = dr[g] & dv[g];
        if (mwe[g]) mem[g][ma[g][7:0]] = mwd[g];
        if (eig || edg) begin
          pv[g]    = 1'b1;
          gc[g]    = c;
          pport[g] = edg;
          paddr[g] = edg ? da[g] : ifa[g];
          pwe[g]   = edg && dwe[g];
          pwd[g]   = dwd[g];
          prd[g]   = pwe[g] ? 32'd0 : shadow[g][paddr[g][7:0]];
          if (pwe[g]) shadow[g][paddr[g][7:0]] = dwd[g];
          rspc[g]    = c + lat[g] + 1;
          free_at[g] = c + lat[g] + 2;
          lastg[g]   = edg;
          exp_ma[g]  = paddr[g];
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
